// File: rtl/pixel_frame_streamer.sv
// pixel_frame_streamer
//   Captures one IX x IY grayscale frame into an internal RAM, then replays
//   it in raster order (x fastest) as a valid/ready stream with SOF/EOL/EOF
//   markers. An optional idle gap of LINE_GAP cycles follows each row except
//   the last.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   i_wr_valid, i_wr_pixel            frame write strobe / data
//   o_wr_ready, o_frame_loaded        accepting writes / full frame stored
//   i_start, o_busy                   start pulse / streaming in progress
//   o_out_valid, o_out_pixel,
//   i_out_ready                       output pixel stream
//   o_sof, o_eol, o_eof               frame/line markers (qualified by valid)
module pixel_frame_streamer #(
    parameter int I_F_BW   = 8,
    parameter int IX       = 28,
    parameter int IY       = 28,
    parameter int LINE_GAP = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_wr_valid,
    input  logic [I_F_BW-1:0] i_wr_pixel,
    output logic              o_wr_ready,
    output logic              o_frame_loaded,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_out_valid,
    output logic [I_F_BW-1:0] o_out_pixel,
    input  logic              i_out_ready,
    output logic              o_sof,
    output logic              o_eol,
    output logic              o_eof
);
    localparam int NPIX = IX * IY;
    localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int CW   = $clog2(NPIX + 1);
    localparam int XW   = (IX > 1) ? $clog2(IX) : 1;
    localparam int YW   = (IY > 1) ? $clog2(IY) : 1;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
    localparam logic [CW-1:0] NPIX_C    = CW'(NPIX);
    localparam logic [XW-1:0] X_LAST    = XW'(IX - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(IY - 1);
    localparam logic [7:0]    GAP_LAST  = 8'(LINE_GAP - 1);

    typedef enum logic [1:0] {S_LOAD, S_READY, S_STREAM, S_GAP} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
    logic [XW-1:0]     ox_q, ox_d;
    logic [YW-1:0]     oy_q, oy_d;
    logic [7:0]        gap_cnt_q, gap_cnt_d;
    logic              ram_vld_q, ram_vld_d;
    logic              out_vld_q, out_vld_d;
    logic [I_F_BW-1:0] out_pix_q, out_pix_d;
    logic              skid_vld_q, skid_vld_d;
    logic [I_F_BW-1:0] skid_pix_q, skid_pix_d;

    logic [I_F_BW-1:0] mem [NPIX];
    logic [I_F_BW-1:0] ram_rdata;

    logic       wr_en, rd_en, pop, at_eol, at_eof;
    logic [1:0] occ;

    always_comb begin
        wr_en  = (state_q == S_LOAD) && i_wr_valid;
        // Only STREAM presents data; prefetched pixels wait out a GAP.
        pop    = (state_q == S_STREAM) && out_vld_q && i_out_ready;
        at_eol = (ox_q == X_LAST);
        at_eof = at_eol && (oy_q == Y_LAST);
        // Output reg + skid give two slots; a read is issued only if the
        // pixel it returns next cycle is guaranteed a free slot.
        occ    = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, ram_vld_q};
        rd_en  = ((state_q == S_STREAM) || (state_q == S_GAP)) &&
                 (rd_cnt_q != NPIX_C) &&
                 ((occ <= 2'd1) || ((occ == 2'd2) && pop));
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr_q] <= i_wr_pixel;
        if (rd_en) ram_rdata <= mem[rd_cnt_q[AW-1:0]];
    end

    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        rd_cnt_d   = rd_en ? rd_cnt_q + 1'b1 : rd_cnt_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        gap_cnt_d  = gap_cnt_q;
        ram_vld_d  = rd_en;
        out_vld_d  = out_vld_q;
        out_pix_d  = out_pix_q;
        skid_vld_d = skid_vld_q;
        skid_pix_d = skid_pix_q;

        // Two-entry output queue: out_pix is the head, skid_pix the tail.
        if (pop) begin
            if (skid_vld_q) begin
                out_pix_d  = skid_pix_q;
                skid_vld_d = ram_vld_q;
                skid_pix_d = ram_rdata;
            end else begin
                out_vld_d = ram_vld_q;
                out_pix_d = ram_vld_q ? ram_rdata : out_pix_q;
            end
        end else if (ram_vld_q) begin
            if (!out_vld_q) begin
                out_vld_d = 1'b1;
                out_pix_d = ram_rdata;
            end else begin
                skid_vld_d = 1'b1;
                skid_pix_d = ram_rdata;
            end
        end

        if (pop) begin
            if (at_eol) begin
                ox_d = '0;
                oy_d = oy_q + 1'b1;
            end else begin
                ox_d = ox_q + 1'b1;
            end
        end

        case (state_q)
            S_LOAD: begin
                if (wr_en) begin
                    if (wr_addr_q == LAST_ADDR) begin
                        wr_addr_d = '0;
                        state_d   = S_READY;
                    end else begin
                        wr_addr_d = wr_addr_q + 1'b1;
                    end
                end
            end
            S_READY: begin
                if (i_start) state_d = S_STREAM;
            end
            S_STREAM: begin
                if (pop && at_eof) begin
                    state_d    = S_LOAD;
                    rd_cnt_d   = '0;
                    ox_d       = '0;
                    oy_d       = '0;
                    ram_vld_d  = 1'b0;
                    out_vld_d  = 1'b0;
                    skid_vld_d = 1'b0;
                end else if (pop && at_eol && (LINE_GAP > 0)) begin
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q == GAP_LAST) state_d = S_STREAM;
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_LOAD;
            wr_addr_q  <= '0;
            rd_cnt_q   <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            gap_cnt_q  <= '0;
            ram_vld_q  <= 1'b0;
            out_vld_q  <= 1'b0;
            out_pix_q  <= '0;
            skid_vld_q <= 1'b0;
            skid_pix_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            rd_cnt_q   <= rd_cnt_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            gap_cnt_q  <= gap_cnt_d;
            ram_vld_q  <= ram_vld_d;
            out_vld_q  <= out_vld_d;
            out_pix_q  <= out_pix_d;
            skid_vld_q <= skid_vld_d;
            skid_pix_q <= skid_pix_d;
        end
    end

    assign o_wr_ready     = (state_q == S_LOAD);
    assign o_frame_loaded = (state_q == S_READY);
    assign o_busy         = (state_q == S_STREAM) || (state_q == S_GAP);
    assign o_out_valid    = (state_q == S_STREAM) && out_vld_q;
    assign o_out_pixel    = out_pix_q;
    assign o_sof          = o_out_valid && (ox_q == '0) && (oy_q == '0);
    assign o_eol          = o_out_valid && at_eol;
    assign o_eof          = o_out_valid && at_eof;

endmodule

// File: tb/tb_pixel_frame_streamer.sv
// Bench: three instances (4x3 no gap, 4x3 gap 3, 28x28 default). Expected
// stream is derived from the written frame array and raster index rules.
module tb_pixel_frame_streamer;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n     [3];
    logic       wr_valid  [3];
    logic [7:0] wr_pixel  [3];
    logic       wr_ready  [3];
    logic       loaded    [3];
    logic       start     [3];
    logic       busy      [3];
    logic       out_valid [3];
    logic [7:0] out_pixel [3];
    logic       out_ready [3];
    logic       sof       [3];
    logic       eol       [3];
    logic       eof       [3];

    int         checks = 0;
    int         errors = 0;
    logic [7:0] frame [784];

    pixel_frame_streamer #(.I_F_BW(8), .IX(4), .IY(3), .LINE_GAP(0)) u_a (
        .clk(clk), .reset_n(rst_n[0]), .i_wr_valid(wr_valid[0]), .i_wr_pixel(wr_pixel[0]),
        .o_wr_ready(wr_ready[0]), .o_frame_loaded(loaded[0]), .i_start(start[0]), .o_busy(busy[0]),
        .o_out_valid(out_valid[0]), .o_out_pixel(out_pixel[0]), .i_out_ready(out_ready[0]),
        .o_sof(sof[0]), .o_eol(eol[0]), .o_eof(eof[0]));

    pixel_frame_streamer #(.I_F_BW(8), .IX(4), .IY(3), .LINE_GAP(3)) u_g (
        .clk(clk), .reset_n(rst_n[1]), .i_wr_valid(wr_valid[1]), .i_wr_pixel(wr_pixel[1]),
        .o_wr_ready(wr_ready[1]), .o_frame_loaded(loaded[1]), .i_start(start[1]), .o_busy(busy[1]),
        .o_out_valid(out_valid[1]), .o_out_pixel(out_pixel[1]), .i_out_ready(out_ready[1]),
        .o_sof(sof[1]), .o_eol(eol[1]), .o_eof(eof[1]));

    pixel_frame_streamer #(.I_F_BW(8)) u_m (
        .clk(clk), .reset_n(rst_n[2]), .i_wr_valid(wr_valid[2]), .i_wr_pixel(wr_pixel[2]),
        .o_wr_ready(wr_ready[2]), .o_frame_loaded(loaded[2]), .i_start(start[2]), .o_busy(busy[2]),
        .o_out_valid(out_valid[2]), .o_out_pixel(out_pixel[2]), .i_out_ready(out_ready[2]),
        .o_sof(sof[2]), .o_eol(eol[2]), .o_eof(eof[2]));

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic chk_idle(input int k);
        chk("idle_wr_ready", int'(wr_ready[k]), 1);
        chk("idle_loaded", int'(loaded[k]), 0);
        chk("idle_busy", int'(busy[k]), 0);
        chk("idle_valid", int'(out_valid[k]), 0);
        chk("idle_markers", int'({sof[k], eol[k], eof[k]}), 0);
    endtask

    // Called on a negedge; writes frame[lo..hi] with random idle cycles.
    task automatic write_range(input int k, input int lo, input int hi, input bit start_last);
        for (int i = lo; i <= hi; i++) begin
            if ($urandom_range(3) == 0) begin
                wr_valid[k] = 1'b0;
                @(negedge clk);
            end
            wr_valid[k] = 1'b1;
            wr_pixel[k] = frame[i];
            start[k]    = start_last && (i == hi);
            @(negedge clk);
        end
        wr_valid[k] = 1'b0;
        start[k]    = 1'b0;
    endtask

    // Pulses start and consumes 'stop' pixels, checking every presented
    // pixel and marker against the raster position of the frame array.
    task automatic stream(input int k, input int ix, input int iy, input int gap,
                          input bit rnd, input int stop, input bit poke);
        int n = ix * iy;
        int idx = 0, first = -1, last = 0, gaprun = 0;
        int n_sof = 0, n_eol = 0, n_eof = 0;
        int limit = n * 8 + gap * iy + 40;
        bit in_gap = 0;
        bit rdy, v;
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        for (int cyc = 0; cyc < limit && idx < stop; cyc++) begin
            v = out_valid[k];
            if (v) begin
                if (first < 0) begin
                    first = cyc;
                    chk("first_valid_latency", cyc, 2);
                end
                if (in_gap) begin
                    if (!rnd) chk("gap_len", gaprun, gap);
                    in_gap = 0;
                end
                chk("pixel", int'(out_pixel[k]), int'(frame[idx]));
                chk("sof", int'(sof[k]), int'(idx == 0));
                chk("eol", int'(eol[k]), int'(idx % ix == ix - 1));
                chk("eof", int'(eof[k]), int'(idx == n - 1));
            end else if (in_gap) begin
                gaprun++;
            end
            rdy = rnd ? 1'($urandom_range(1)) : 1'b1;
            out_ready[k] = rdy;
            if (poke) begin
                wr_valid[k] = 1'($urandom_range(1));
                wr_pixel[k] = 8'hEE;
            end
            if (v && rdy) begin
                n_sof += int'(sof[k]);
                n_eol += int'(eol[k]);
                n_eof += int'(eof[k]);
                last = cyc;
                if ((idx % ix == ix - 1) && (idx != n - 1) && (gap > 0)) begin
                    in_gap = 1;
                    gaprun = 0;
                end
                idx++;
            end
            @(negedge clk);
        end
        wr_valid[k]  = 1'b0;
        out_ready[k] = 1'b1;
        chk("handshakes", idx, stop);
        if (stop == n) begin
            chk("sof_count", n_sof, 1);
            chk("eol_count", n_eol, iy);
            chk("eof_count", n_eof, 1);
            if (!rnd) chk("valid_span", last - first + 1, n + gap * (iy - 1));
            chk_idle(k);
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; wr_valid[k] = 1'b0; wr_pixel[k] = '0;
            start[k] = 1'b0; out_ready[k] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk_idle(k);
            chk("reset_pixel", int'(out_pixel[k]), 0);
            rst_n[k] = 1'b1;
        end
        @(negedge clk);

        // Basic 4x3 frame, ready held high
        for (int i = 0; i < 12; i++) frame[i] = 8'(i);
        write_range(0, 0, 11, 1'b0);
        chk("loaded", int'(loaded[0]), 1);
        chk("wr_ready_low", int'(wr_ready[0]), 0);
        stream(0, 4, 3, 0, 1'b0, 12, 1'b0);

        // Same frame, random backpressure
        write_range(0, 0, 11, 1'b0);
        stream(0, 4, 3, 0, 1'b1, 12, 1'b0);

        // Line gap of 3
        write_range(1, 0, 11, 1'b0);
        stream(1, 4, 3, 3, 1'b0, 12, 1'b0);
        write_range(1, 0, 11, 1'b0);
        stream(1, 4, 3, 3, 1'b1, 12, 1'b0);

        // Start during LOAD ignored, start with last write ignored,
        // writes during STREAM ignored
        for (int i = 0; i < 12; i++) frame[i] = 8'($urandom_range(255));
        write_range(0, 0, 4, 1'b0);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("start_in_load_busy", int'(busy[0]), 0);
        chk("start_in_load_valid", int'(out_valid[0]), 0);
        chk("start_in_load_wr_ready", int'(wr_ready[0]), 1);
        write_range(0, 5, 11, 1'b1);
        chk("loaded_after_partial", int'(loaded[0]), 1);
        repeat (3) @(negedge clk);
        chk("start_on_last_busy", int'(busy[0]), 0);
        chk("start_on_last_valid", int'(out_valid[0]), 0);
        chk("start_on_last_loaded", int'(loaded[0]), 1);
        stream(0, 4, 3, 0, 1'b1, 12, 1'b1);
        for (int i = 0; i < 12; i++) frame[i] = 8'($urandom_range(255));
        write_range(0, 0, 11, 1'b0);
        stream(0, 4, 3, 0, 1'b1, 12, 1'b0);

        // Reset mid-stream
        for (int i = 0; i < 12; i++) frame[i] = 8'(i);
        write_range(0, 0, 11, 1'b0);
        stream(0, 4, 3, 0, 1'b0, 5, 1'b0);
        rst_n[0] = 1'b0;
        #1;
        chk("rst_valid", int'(out_valid[0]), 0);
        chk("rst_busy", int'(busy[0]), 0);
        chk("rst_pixel", int'(out_pixel[0]), 0);
        chk("rst_markers", int'({sof[0], eol[0], eof[0]}), 0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        chk("rst_wr_ready", int'(wr_ready[0]), 1);
        for (int i = 0; i < 12; i++) frame[i] = 8'(100 + i);
        write_range(0, 0, 11, 1'b0);
        stream(0, 4, 3, 0, 1'b0, 12, 1'b0);

        // 28x28 random frame
        for (int i = 0; i < 784; i++) frame[i] = 8'($urandom_range(255));
        write_range(2, 0, 783, 1'b0);
        chk("mnist_loaded", int'(loaded[2]), 1);
        stream(2, 28, 28, 0, 1'b0, 784, 1'b0);
        write_range(2, 0, 783, 1'b0);
        stream(2, 28, 28, 0, 1'b1, 784, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
